// File: rtl/mdu_e.sv
// mdu_e -- E-stage multiply/divide unit with HI/LO registers.
// Multiplies take 5 busy cycles and divides take 10. The result is computed
// from operands captured at launch and lands in HI/LO on the final busy edge.
// mthi/mtlo write HI/LO directly while the unit is idle.
module mdu_e (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [2:0]  mdu_op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic        rd_hi,
  output logic        busy,
  output logic        stall_req,
  output logic [31:0] hi,
  output logic [31:0] lo,
  output logic [31:0] mdu_out
);

  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] BUSY = 1'b1;

  localparam logic [2:0] OP_NONE  = 3'd0;
  localparam logic [2:0] OP_MULT  = 3'd1;
  localparam logic [2:0] OP_MULTU = 3'd2;
  localparam logic [2:0] OP_DIV   = 3'd3;
  localparam logic [2:0] OP_DIVU  = 3'd4;
  localparam logic [2:0] OP_MTHI  = 3'd5;
  localparam logic [2:0] OP_MTLO  = 3'd6;

  localparam logic [3:0] MUL_CYCLES = 4'd5;
  localparam logic [3:0] DIV_CYCLES = 4'd10;

  // 64-bit product. Sign-extending both operands to 64 bits gives the
  // signed product in the low 64 bits of a plain multiply.
  function automatic logic [63:0] mul64(input logic [31:0] x,
                                        input logic [31:0] y,
                                        input logic        sgn);
    logic [63:0] xe;
    logic [63:0] ye;
    xe = sgn ? {{32{x[31]}}, x} : {32'd0, x};
    ye = sgn ? {{32{y[31]}}, y} : {32'd0, y};
    return xe * ye;
  endfunction

  // Divide on magnitudes, then restore the signs. The quotient truncates
  // toward zero and the remainder takes the sign of the dividend. The
  // magnitude of 0x80000000 is still 0x80000000 as an unsigned value, so
  // 0x80000000 / -1 yields quotient 0x80000000 and remainder 0.
  // The return value is packed as {remainder, quotient}.
  function automatic logic [63:0] div64(input logic [31:0] x,
                                        input logic [31:0] y,
                                        input logic        sgn);
    logic        x_neg;
    logic        y_neg;
    logic [31:0] xm;
    logic [31:0] ym;
    logic [31:0] q;
    logic [31:0] r;
    x_neg = sgn & x[31];
    y_neg = sgn & y[31];
    xm = x_neg ? (32'd0 - x) : x;
    ym = y_neg ? (32'd0 - y) : y;
    if (ym == 32'd0) begin
      q = 32'd0;
      r = 32'd0;
    end else begin
      q = xm / ym;
      r = xm % ym;
    end
    q = (x_neg ^ y_neg) ? (32'd0 - q) : q;
    r = x_neg ? (32'd0 - r) : r;
    return {r, q};
  endfunction

  logic [0:0]  state_r;
  logic [3:0]  cnt_r;
  logic [31:0] a_r;
  logic [31:0] b_r;
  logic [2:0]  op_r;
  logic [31:0] hi_r;
  logic [31:0] lo_r;

  logic        launch_s;
  logic        finish_s;
  logic        res_wr_s;
  logic [63:0] res_s;

  assign launch_s = (state_r == IDLE) && start &&
                    ((mdu_op == OP_MULT) || (mdu_op == OP_MULTU) ||
                     (mdu_op == OP_DIV)  || (mdu_op == OP_DIVU));
  assign finish_s = (state_r == BUSY) && (cnt_r == 4'd1);

  // Select the result for the latched operation; a zero divisor suppresses the write.
  always_comb begin
    res_s    = 64'd0;
    res_wr_s = 1'b0;
    case (op_r)
      OP_MULT: begin
        res_s    = mul64(a_r, b_r, 1'b1);
        res_wr_s = 1'b1;
      end
      OP_MULTU: begin
        res_s    = mul64(a_r, b_r, 1'b0);
        res_wr_s = 1'b1;
      end
      OP_DIV: begin
        res_s    = div64(a_r, b_r, 1'b1);
        res_wr_s = (b_r != 32'd0);
      end
      OP_DIVU: begin
        res_s    = div64(a_r, b_r, 1'b0);
        res_wr_s = (b_r != 32'd0);
      end
      default: begin
        res_s    = 64'd0;
        res_wr_s = 1'b0;
      end
    endcase
  end

  // Sequencer: capture operands at launch, count down the busy cycles, and return to idle.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r <= IDLE;
      cnt_r   <= 4'd0;
      a_r     <= 32'd0;
      b_r     <= 32'd0;
      op_r    <= OP_NONE;
    end else begin
      case (state_r)
        IDLE: begin
          if (launch_s) begin
            a_r     <= a;
            b_r     <= b;
            op_r    <= mdu_op;
            cnt_r   <= ((mdu_op == OP_MULT) || (mdu_op == OP_MULTU)) ? MUL_CYCLES : DIV_CYCLES;
            state_r <= BUSY;
          end
        end
        BUSY: begin
          cnt_r <= (cnt_r == 4'd0) ? 4'd0 : (cnt_r - 4'd1);
          if (cnt_r <= 4'd1) begin
            state_r <= IDLE;
          end
        end
        default: begin
          state_r <= IDLE;
          cnt_r   <= 4'd0;
        end
      endcase
    end
  end

  // HI/LO: load the result on the final busy edge, or take mthi/mtlo while idle.
  always_ff @(posedge clk) begin
    if (reset) begin
      hi_r <= 32'd0;
      lo_r <= 32'd0;
    end else if (finish_s) begin
      if (res_wr_s) begin
        hi_r <= res_s[63:32];
        lo_r <= res_s[31:0];
      end
    end else if (state_r == IDLE) begin
      if (mdu_op == OP_MTHI) begin
        hi_r <= a;
      end else if (mdu_op == OP_MTLO) begin
        lo_r <= a;
      end
    end
  end

  assign busy      = (state_r == BUSY);
  assign stall_req = start | busy;
  assign hi        = hi_r;
  assign lo        = lo_r;
  assign mdu_out   = rd_hi ? hi_r : lo_r;

endmodule

// File: doc/mdu_e.md
MDU_E -- requirements
Module: mdu_e

Interface
REQ-001 The block SHALL use reset reset, synchronous, active-high; clock clk.
REQ-002 Ports SHALL be:
- clk  in  1  clock
- reset  in  1  sync active-high reset
- start  in  1  one-cycle launch strobe for mult/multu/div/divu in E stage
- mdu_op  in  3  0 none, 1 mult, 2 multu, 3 div, 4 divu, 5 mthi, 6 mtlo
- a  in  32  forwarded rs value
- b  in  32  forwarded rt value
- rd_hi  in  1  1 selects HI, 0 selects LO on mdu_out
- busy  out  1  operation in progress
- stall_req  out  1  start | busy, to hazard unit
- hi  out  32  HI register
- lo  out  32  LO register
- mdu_out  out  32  rd_hi ? hi : lo, for mfhi/mflo into ALUOut path

Function
REQ-003 The block SHALL have two states, IDLE and BUSY, plus a 4-bit cycle counter.
REQ-004 In IDLE with start=1 and mdu_op in {1..4}, the block SHALL latch a, b and mdu_op, load the counter with 5 (mult/multu) or 10 (div/divu), and enter BUSY on the next edge.
REQ-005 In BUSY, the counter SHALL decrement once per cycle; busy SHALL be 1 for exactly 5 (mult) or 10 (div) consecutive cycles, starting the cycle after start.
REQ-006 On the edge where the counter goes 1->0, HI/LO SHALL update from the latched operands and the state SHALL return to IDLE; busy=0 and new hi/lo SHALL be visible in the same cycle.
REQ-007 mult: {HI,LO} = signed 64-bit product; multu: unsigned 64-bit product.
REQ-008 div: LO = signed quotient truncated toward zero, HI = remainder with the sign of the dividend; divu: unsigned quotient/remainder.
REQ-009 div 0x80000000 / 0xFFFFFFFF SHALL give LO=0x80000000, HI=0x00000000.
REQ-010 Division by zero (b=0) SHALL run the full 10 busy cycles and SHALL leave HI and LO unchanged.
REQ-011 mdu_op 5 (mthi) / 6 (mtlo) SHALL write a into HI / LO on the next edge, in IDLE only, regardless of start.
REQ-012 start, mthi and mtlo SHALL be ignored while busy=1; the hazard unit guarantees no such issue, and the block SHALL NOT corrupt the in-flight operation if one occurs.
REQ-013 start with mdu_op in {0,5,6} SHALL NOT enter BUSY.
REQ-014 start and mdu_op 5/6 arriving in the same IDLE cycle is illegal encoding; mdu_op SHALL decide, so 1..4 launches and 5/6 writes.
REQ-015 Operands SHALL be sampled only at launch; changes on a/b during BUSY SHALL NOT affect the result.
REQ-016 stall_req SHALL be combinational start | busy.
REQ-017 mdu_out SHALL be combinational from the current hi/lo registers; reading during BUSY returns the pre-operation values.

Reset
REQ-018 When reset=1 at an edge, the block SHALL set state=IDLE, counter=0, busy=0, hi=0, lo=0, and clear the latched operands and op.
REQ-019 Reset during BUSY SHALL abandon the operation with no HI/LO update; the cycle after reset deasserts, the block SHALL accept a new start.
REQ-020 Reset SHALL take priority over start, mthi and mtlo in the same cycle.

Verification
REQ-021 mult a=0xFFFFFFFE (-2), b=3, start pulse -> busy high for cycles 1..5; after busy falls, HI=0xFFFFFFFF, LO=0xFFFFFFFA.
REQ-022 multu a=0xFFFFFFFF, b=0xFFFFFFFF -> after 5 busy cycles, HI=0xFFFFFFFE, LO=0x00000001.
REQ-023 div a=0xFFFFFFF9 (-7), b=2 -> busy for 10 cycles, then LO=0xFFFFFFFD, HI=0xFFFFFFFF; also check 0x80000000/-1 per REQ-009.
REQ-024 mthi a=0x12345678, then divu with b=0 -> HI stays 0x12345678 after the full 10 busy cycles, LO unchanged.
REQ-025 Start a mult, assert reset on busy cycle 3 -> busy=0, hi=lo=0 next cycle; a fresh mult 6*7 then gives LO=42, HI=0.
REQ-026 Start a div, then during busy pulse start with mult, apply mtlo, and toggle a/b -> none of these take effect; div result correct, busy length exactly 10.
